// File: rtl/cdb_wb_arbiter.sv
`default_nettype none
// ==== cdb_wb_arbiter: per-FU result slots, round-robin grant, registered CDB writeback ====
// ==== Revision: 1.0 ====
module cdb_wb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = 5
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_FU-1:0]          fu_valid,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU*REG_W-1:0]    fu_rd,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  input  logic [NUM_FU-1:0]          fu_spec,
  input  logic                       flush,
  input  logic                       spec_clear,
  output logic                       wb_valid,
  output logic                       wb_write,
  output logic [REG_W-1:0]           wb_sel,
  output logic [TAG_W-1:0]           wb_tag,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       wb_spec
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] r_slot_valid;
  logic [NUM_FU-1:0] r_slot_spec;
  logic [REG_W-1:0]  r_slot_rd   [NUM_FU];
  logic [TAG_W-1:0]  r_slot_tag  [NUM_FU];
  logic [DATA_W-1:0] r_slot_data [NUM_FU];
  logic [PTR_W-1:0]  r_rr_ptr;

  logic [NUM_FU-1:0] w_eligible;
  logic [NUM_FU-1:0] w_grant;
  logic [PTR_W-1:0]  w_gidx;
  logic              w_any_grant;
  logic              w_spec_clr;

  // flush takes priority over a simultaneous spec_clear
  assign w_spec_clr = spec_clear & ~flush;
  assign w_eligible = r_slot_valid & ~(r_slot_spec & {NUM_FU{flush}});
  assign fu_ready   = ~r_slot_valid | w_grant;

  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_gidx      = '0;
    w_any_grant = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!w_any_grant && w_eligible[idx]) begin
        w_grant[idx] = 1'b1;
        w_gidx       = PTR_W'(idx);
        w_any_grant  = 1'b1;
      end
    end
  end

  // A handshake only happens on an empty or granted slot, so loading wins over release
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_slot_valid[i] <= 1'b0;
        r_slot_spec[i]  <= 1'b0;
        r_slot_rd[i]    <= '0;
        r_slot_tag[i]   <= '0;
        r_slot_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          r_slot_valid[i] <= ~(flush & fu_spec[i]);
          r_slot_spec[i]  <= fu_spec[i] & ~w_spec_clr;
          r_slot_rd[i]    <= fu_rd[i*REG_W +: REG_W];
          r_slot_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
          r_slot_data[i]  <= fu_data[i*DATA_W +: DATA_W];
        end else if (w_grant[i] || (flush && r_slot_spec[i])) begin
          r_slot_valid[i] <= 1'b0;
        end else if (w_spec_clr) begin
          r_slot_spec[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr_ptr <= '0;
      wb_valid <= 1'b0;
      wb_write <= 1'b0;
      wb_sel   <= '0;
      wb_tag   <= '0;
      wb_data  <= '0;
      wb_spec  <= 1'b0;
    end else if (w_any_grant) begin
      wb_valid <= 1'b1;
      wb_write <= (r_slot_rd[w_gidx] != '0);
      wb_sel   <= r_slot_rd[w_gidx];
      wb_tag   <= r_slot_tag[w_gidx];
      wb_data  <= r_slot_data[w_gidx];
      wb_spec  <= r_slot_spec[w_gidx] & ~w_spec_clr;
      r_rr_ptr <= (w_gidx == PTR_W'(NUM_FU - 1)) ? '0 : w_gidx + PTR_W'(1);
    end else begin
      wb_valid <= 1'b0;
      wb_write <= 1'b0;
      wb_spec  <= wb_spec & ~(spec_clear | flush);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_wb_arbiter.sv
`default_nettype none
// ==== tb_cdb_wb_arbiter: directed table plus randomized run against a reference model ====
// ==== Revision: 1.0 ====
module tb_cdb_wb_arbiter;

  localparam int N = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [N-1:0]  fu_valid, fu_ready, fu_spec;
  logic [N*5-1:0]  fu_rd, fu_tag;
  logic [N*32-1:0] fu_data;
  logic          flush, spec_clear;
  logic          wb_valid, wb_write, wb_spec;
  logic [4:0]    wb_sel, wb_tag;
  logic [31:0]   wb_data;

  int n_chk = 0;
  int n_err = 0;

  cdb_wb_arbiter #(.NUM_FU(N), .DATA_W(32), .REG_W(5), .TAG_W(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rd(fu_rd), .fu_tag(fu_tag),
    .fu_data(fu_data), .fu_spec(fu_spec), .flush(flush), .spec_clear(spec_clear),
    .wb_valid(wb_valid), .wb_write(wb_write), .wb_sel(wb_sel), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_spec(wb_spec)
  );

  always #5 CLK = ~CLK;

  // Reference model: one-deep holding slot per FU, pointer-based fair pick
  bit         m_v [N];
  bit         m_sp[N];
  logic [4:0] m_rd[N];
  logic [4:0] m_tag[N];
  logic [31:0] m_data[N];
  int         m_rr;
  bit         o_v, o_w, o_sp;
  logic [4:0] o_sel, o_tag;
  logic [31:0] o_data;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_sp[i] = 0; m_rd[i] = 0; m_tag[i] = 0; m_data[i] = 0;
    end
    m_rr = 0; o_v = 0; o_w = 0; o_sp = 0; o_sel = 0; o_tag = 0; o_data = 0;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (m_v[i] && !(flush && m_sp[i])) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_pick();
    for (int i = 0; i < N; i++) r[i] = !m_v[i] || (g == i);
    return r;
  endfunction

  function automatic void m_step();
    int g;
    logic [N-1:0] rdy;
    bit sclr;
    g    = m_pick();
    rdy  = m_ready();
    sclr = spec_clear && !flush;
    if (g >= 0) begin
      o_v = 1; o_w = (m_rd[g] != 0); o_sel = m_rd[g]; o_tag = m_tag[g];
      o_data = m_data[g]; o_sp = m_sp[g] && !sclr;
      m_rr = (g + 1) % N;
    end else begin
      o_v = 0; o_w = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (fu_valid[i] && rdy[i]) begin
        m_v[i]    = !(flush && fu_spec[i]);
        m_sp[i]   = fu_spec[i] && !sclr;
        m_rd[i]   = fu_rd[i*5 +: 5];
        m_tag[i]  = fu_tag[i*5 +: 5];
        m_data[i] = fu_data[i*32 +: 32];
      end else if (g == i || (flush && m_sp[i])) begin
        m_v[i] = 0;
      end else if (sclr) begin
        m_sp[i] = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // FU i presents rd+i, tag+i, data+i
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] sp, input logic fl,
                       input logic sc, input logic [4:0] rd, input logic [4:0] tag,
                       input logic [31:0] data);
    fu_valid = v; fu_spec = sp; flush = fl; spec_clear = sc;
    for (int i = 0; i < N; i++) begin
      fu_rd[i*5 +: 5]    = rd + 5'(i);
      fu_tag[i*5 +: 5]   = tag + 5'(i);
      fu_data[i*32 +: 32] = data + 32'(i);
    end
  endtask

  task automatic step_model();
    chk("fu_ready model", fu_ready, m_ready());
    @(posedge CLK);
    m_step();
    #1;
    chk("wb_valid model", wb_valid, o_v);
    chk("wb_write model", wb_write, o_w);
    if (o_v) begin
      chk("wb_sel model", wb_sel, o_sel);
      chk("wb_tag model", wb_tag, o_tag);
      chk("wb_data model", wb_data, o_data);
      chk("wb_spec model", wb_spec, o_sp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] v;
    logic [N-1:0] sp;
    logic         fl;
    logic         sc;
    logic [4:0]   rd;
    logic [4:0]   tag;
    logic [31:0]  data;
    logic [N-1:0] e_rdy;
    logic         e_v;
    logic         e_w;
    logic [4:0]   e_sel;
    logic [4:0]   e_tag;
    logic [31:0]  e_data;
    logic         e_sp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] sp, logic fl, logic sc,
                              logic [4:0] rd, logic [4:0] tag, logic [31:0] data,
                              logic [3:0] e_rdy, logic e_v, logic e_w, logic [4:0] e_sel,
                              logic [4:0] e_tag, logic [31:0] e_data, logic e_sp);
    vec_t t;
    t.v = v; t.sp = sp; t.fl = fl; t.sc = sc; t.rd = rd; t.tag = tag; t.data = data;
    t.e_rdy = e_rdy; t.e_v = e_v; t.e_w = e_w; t.e_sel = e_sel; t.e_tag = e_tag;
    t.e_data = e_data; t.e_sp = e_sp;
    return t;
  endfunction

  initial begin
    // fairness: all four held valid, grants cycle 0,1,2,3,0,1,2,3 then drain
    tbl.push_back(mk(4'hF, 0, 0, 0, 8, 0, 32'hF00, 4'b1111, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r < 8; r++)
      tbl.push_back(mk(4'hF, 0, 0, 0, 8, 0, 32'hF00, 4'(1 << (r % 4)), 1, 1,
                       5'(8 + r % 4), 5'(r % 4), 32'hF00 + 32'(r % 4), 0));
    tbl.push_back(mk(4'h0, 0, 0, 0, 8, 0, 32'hF00, 4'b0001, 1, 1, 8, 0, 32'hF00, 0));
    tbl.push_back(mk(4'h0, 0, 0, 0, 8, 0, 32'hF00, 4'b0011, 1, 1, 9, 1, 32'hF01, 0));
    tbl.push_back(mk(4'h0, 0, 0, 0, 8, 0, 32'hF00, 4'b0111, 1, 1, 10, 2, 32'hF02, 0));
    tbl.push_back(mk(4'h0, 0, 0, 0, 8, 0, 32'hF00, 4'b1111, 1, 1, 11, 3, 32'hF03, 0));
    tbl.push_back(mk(4'h0, 0, 0, 0, 8, 0, 32'hF00, 4'b1111, 0, 0, 0, 0, 0, 0));
    // contention FU0 and FU2 with pointer at 0
    tbl.push_back(mk(4'b0101, 0, 0, 0, 4, 10, 32'h1000, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4, 10, 32'h1000, 4'b1011, 1, 1, 4, 10, 32'h1000, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4, 10, 32'h1000, 4'b1111, 1, 1, 6, 12, 32'h1002, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4, 10, 32'h1000, 4'b1111, 0, 0, 0, 0, 0, 0));
    // single result FU1 rd=7 tag=3 data=DEAD
    tbl.push_back(mk(4'b0010, 0, 0, 0, 6, 2, 32'hDEAC, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 6, 2, 32'hDEAC, 4'b1111, 1, 1, 7, 3, 32'hDEAD, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 6, 2, 32'hDEAC, 4'b1111, 0, 0, 0, 0, 0, 0));
    // register zero: FU3 rd=0 tag=9, tag broadcast without status clear
    tbl.push_back(mk(4'b1000, 0, 0, 0, 29, 6, 32'h55, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 29, 6, 32'h55, 4'b1111, 1, 0, 0, 9, 32'h58, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 29, 6, 32'h55, 4'b1111, 0, 0, 0, 0, 0, 0));
    // flush squashes speculative slot 0, slot 1 proceeds
    tbl.push_back(mk(4'b0011, 4'b0001, 0, 0, 2, 20, 32'hA0, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 1, 0, 2, 20, 32'hA0, 4'b1110, 1, 1, 3, 21, 32'hA1, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 2, 20, 32'hA0, 4'b1111, 0, 0, 0, 0, 0, 0));
    // speculative broadcast in flight, then flush
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 0, 2, 20, 32'hB0, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 2, 20, 32'hB0, 4'b1111, 1, 1, 4, 22, 32'hB2, 1));
    tbl.push_back(mk(4'b0000, 0, 1, 0, 2, 20, 32'hB0, 4'b1111, 0, 0, 0, 0, 0, 0));
    // spec_clear on incoming handshake, so a later flush keeps it
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 1, 1, 1, 32'hC0, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 1, 0, 1, 1, 32'hC0, 4'b1111, 1, 1, 4, 4, 32'hC3, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 1, 32'hC0, 4'b1111, 0, 0, 0, 0, 0, 0));
    // FU0 streams three results back to back
    tbl.push_back(mk(4'b0001, 0, 0, 0, 1, 1, 32'h100, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 0, 0, 1, 1, 32'h200, 4'b1111, 1, 1, 1, 1, 32'h100, 0));
    tbl.push_back(mk(4'b0001, 0, 0, 0, 1, 1, 32'h300, 4'b1111, 1, 1, 1, 1, 32'h200, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 1, 32'h300, 4'b1111, 1, 1, 1, 1, 32'h300, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 1, 1, 32'h300, 4'b1111, 0, 0, 0, 0, 0, 0));
    // speculative handshake during flush is accepted and dropped
    tbl.push_back(mk(4'b0010, 4'b0010, 1, 0, 0, 0, 32'hE0, 4'b1111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 32'hE0, 4'b1111, 0, 0, 0, 0, 0, 0));

    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #12;
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_write", wb_write, 0);
    chk("reset wb_sel", wb_sel, 0);
    chk("reset wb_tag", wb_tag, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset wb_spec", wb_spec, 0);
    chk("reset fu_ready", fu_ready, 4'hF);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    foreach (tbl[r]) begin
      drive(tbl[r].v, tbl[r].sp, tbl[r].fl, tbl[r].sc, tbl[r].rd, tbl[r].tag, tbl[r].data);
      #1;
      chk($sformatf("tbl%0d fu_ready", r), fu_ready, tbl[r].e_rdy);
      step_model();
      chk($sformatf("tbl%0d wb_valid", r), wb_valid, tbl[r].e_v);
      chk($sformatf("tbl%0d wb_write", r), wb_write, tbl[r].e_w);
      if (tbl[r].e_v) begin
        chk($sformatf("tbl%0d wb_sel", r), wb_sel, tbl[r].e_sel);
        chk($sformatf("tbl%0d wb_tag", r), wb_tag, tbl[r].e_tag);
        chk($sformatf("tbl%0d wb_data", r), wb_data, tbl[r].e_data);
        chk($sformatf("tbl%0d wb_spec", r), wb_spec, tbl[r].e_sp);
      end
    end

    // reset pulsed while every slot is full and a broadcast is showing
    drive(4'hF, 0, 0, 0, 10, 1, 32'h77);
    #1;
    step_model();
    drive(0, 0, 0, 0, 10, 1, 32'h77);
    #1;
    step_model();
    chk("pre-reset wb_valid", wb_valid, 1);
    #2;
    nRST = 1'b0;
    #1;
    m_reset();
    chk("async reset wb_valid", wb_valid, 0);
    chk("async reset wb_write", wb_write, 0);
    chk("async reset wb_data", wb_data, 0);
    chk("async reset wb_sel", wb_sel, 0);
    chk("async reset fu_ready", fu_ready, 4'hF);
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step_model();
      chk("post-reset idle wb_valid", wb_valid, 0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      fu_valid   = 4'($urandom);
      fu_spec    = 4'($urandom) & 4'($urandom);
      flush      = ($urandom_range(0, 9) == 0);
      spec_clear = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        fu_rd[i*5 +: 5]     = 5'($urandom);
        fu_tag[i*5 +: 5]    = 5'($urandom);
        fu_data[i*32 +: 32] = $urandom;
      end
      #1;
      step_model();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
